// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the burst sequencer around the small register-file memory.
package mem_burst_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 4;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// 2**AW x DW storage: synchronous write port, asynchronous read port, no reset on contents.
module mem_array #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: one read/write command at a time, streams beats to/from mem_array.
// Optional BURST_CHECKSUM_EN builds an XOR accumulator of burst data on chk.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | accepting write beats, wr_ready high
// READ  | presenting registered read beats until the last handshake
import mem_burst_pkg::*;

module mem_burst_ctrl #(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          done,
   output logic [DW-1:0] chk
);

   state_t        state, state_nxt;
   logic [AW-1:0] addr, cnt, addr_inc, raddr;
   logic [DW-1:0] mem_rdata;
   logic          cmd_acc, beat, last, mem_we;

   mem_array #(.DW(DW), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (addr),
      .wdata (wr_data),
      .raddr (raddr),
      .rdata (mem_rdata)
   );

   assign addr_inc  = addr + 1'b1;
   // Look ahead one word so rd_data can be loaded on the same edge a beat completes
   assign raddr     = (state == IDLE) ? cmd_addr : addr_inc;
   assign cmd_ready = (state == IDLE);
   assign wr_ready  = (state == WRITE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_acc   = 1'b0;
      beat      = 1'b0;
      mem_we    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               cmd_acc   = 1'b1;
               state_nxt = (cmd_write == CMD_WRITE) ? WRITE : READ;
            end
         end
         WRITE: begin
            beat   = wr_valid;
            mem_we = wr_valid;
         end
         READ: begin
            beat = rd_valid && rd_ready;
         end
         default: state_nxt = IDLE;
      endcase
      last = beat && (cnt == '0);
      if (last) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         cnt      <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
      end else begin
         done <= last;
         if (cmd_acc) begin
            addr <= cmd_addr;
            cnt  <= cmd_len;
            if (cmd_write == CMD_READ) begin
               rd_valid <= 1'b1;
               rd_data  <= mem_rdata;
            end
         end else if (beat) begin
            addr <= addr_inc;
            cnt  <= cnt - 1'b1;
            if (state == READ) begin
               if (last) rd_valid <= 1'b0;
               else      rd_data  <= mem_rdata;
            end
         end
      end
   end

`ifdef BURST_CHECKSUM_EN
   logic [DW-1:0] beat_data;
   logic [DW-1:0] chk_q;

   assign beat_data = (state == WRITE) ? wr_data : rd_data;

   always_ff @(posedge clk) begin
      if (rst)          chk_q <= '0;
      else if (cmd_acc) chk_q <= '0;
      else if (beat)    chk_q <= chk_q ^ beat_data;
   end

   assign chk = chk_q;
`else
   assign chk = '0;
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl; honours BURST_CHECKSUM_EN for the chk expectations.
module tb_mem_burst_ctrl;
   import mem_burst_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr, cmd_len;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       rd_valid, rd_ready;
   logic [7:0] rd_data;
   logic       done;
   logic [7:0] chk;

   int total = 0;
   int bad   = 0;

   logic [7:0] model_mem [16];
   logic [7:0] wq [$];
   logic [7:0] sq [$];

   mem_burst_ctrl #(.DW(8), .AW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .done      (done),
      .chk       (chk)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_chk(input logic [7:0] xs);
`ifdef BURST_CHECKSUM_EN
      return xs;
`else
      return 8'h00;
`endif
   endfunction

   task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
      int waitc = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int gap_at,
                           input int gap_n, input bit hold_cmd, input string name);
      int beats = 0, gaps = 0, cyc = 0;
      logic [7:0] x;
      logic [7:0] xs = 8'h00;
      send_cmd(CMD_WRITE, a, l);
      while (beats <= int'(l) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (hold_cmd) begin
            cmd_valid = 1'b1;
            cmd_write = CMD_READ;
            cmd_addr  = 4'd0;
         end else begin
            cmd_valid = 1'b0;
         end
         total++;
         if ({wr_ready, done, rd_valid} !== 3'b100) begin
            bad++;
            $display("FAIL %s_beat wr_ready/done/rd_valid got=%b exp=100", name,
                     {wr_ready, done, rd_valid});
            break;
         end
         if (beats == gap_at && gaps < gap_n) begin
            wr_valid = 1'b0;
            wr_data  = 8'h5A;
            gaps++;
         end else begin
            x = wq.pop_front();
            wr_valid = 1'b1;
            wr_data  = x;
            model_mem[4'(int'(a) + beats)] = x;
            xs ^= x;
            beats++;
         end
      end
      @(negedge clk);
      wr_valid  = 1'b0;
      cmd_valid = 1'b0;
      wr_data   = 8'h33;
      total++;
      if ({done, cmd_ready, wr_ready, rd_valid} !== 4'b1100) begin
         bad++;
         $display("FAIL %s_end done/cmd_ready/wr_ready/rd_valid got=%b exp=1100", name,
                  {done, cmd_ready, wr_ready, rd_valid});
      end
      total++;
      if (chk !== exp_chk(xs)) begin
         bad++;
         $display("FAIL %s_chk got=%h exp=%h", name, chk, exp_chk(xs));
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || chk !== exp_chk(xs)) begin
         bad++;
         $display("FAIL %s_after done/chk got=%b/%h exp=0/%h", name, done, chk, exp_chk(xs));
      end
      wq.delete();
   endtask

   task automatic do_read(input logic [3:0] a, input logic [3:0] l, input bit stall,
                          input string name);
      int beats = 0, cyc = 0, k = 0;
      bit stalled = 1'b0;
      logic [7:0] prev = 8'h00;
      logic [7:0] e;
      logic [7:0] xs = 8'h00;
      for (int i = 0; i <= int'(l); i++) sq.push_back(model_mem[4'(int'(a) + i)]);
      send_cmd(CMD_READ, a, l);
      while (beats <= int'(l) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         cmd_valid = 1'b0;
         total++;
         if (rd_valid !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_valid rd_valid/done got=%b%b exp=10", name, rd_valid, done);
            break;
         end
         if (stalled) begin
            total++;
            if (rd_data !== prev) begin
               bad++;
               $display("FAIL %s_stable rd_data got=%h exp=%h", name, rd_data, prev);
            end
         end
         rd_ready = !stall || (k % 3 == 0);
         k++;
         if (rd_ready) begin
            e = sq.pop_front();
            total++;
            if (rd_data !== e) begin
               bad++;
               $display("FAIL %s_data beat=%0d got=%h exp=%h", name, beats, rd_data, e);
            end
            xs ^= e;
            beats++;
         end
         prev    = rd_data;
         stalled = !rd_ready;
      end
      @(negedge clk);
      rd_ready = 1'b0;
      total++;
      if ({done, cmd_ready, rd_valid, wr_ready} !== 4'b1100) begin
         bad++;
         $display("FAIL %s_end done/cmd_ready/rd_valid/wr_ready got=%b exp=1100", name,
                  {done, cmd_ready, rd_valid, wr_ready});
      end
      total++;
      if (chk !== exp_chk(xs)) begin
         bad++;
         $display("FAIL %s_chk got=%h exp=%h", name, chk, exp_chk(xs));
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL %s_after done got=%b exp=0", name, done);
      end
      sq.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
      wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({cmd_ready, wr_ready, rd_valid, done} !== 4'b1000 || rd_data !== 8'h00 || chk !== 8'h00) begin
         bad++;
         $display("FAIL reset cmd_ready/wr_ready/rd_valid/done=%b rd_data=%h chk=%h exp=1000/00/00",
                  {cmd_ready, wr_ready, rd_valid, done}, rd_data, chk);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_burst();
      wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_write(4'd4, 4'd3, -1, 0, 1'b0, "wr4");
   endtask

   task automatic test_read_burst();
      do_read(4'd4, 4'd3, 1'b0, "rd4");
   endtask

   task automatic test_idle_ignore();
      wq = '{8'h77};
      do_write(4'd3, 4'd0, -1, 0, 1'b0, "wr3");
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({cmd_ready, wr_ready, rd_valid, done} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_ignore cmd_ready/wr_ready/rd_valid/done got=%b exp=1000",
                     {cmd_ready, wr_ready, rd_valid, done});
         end
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      do_read(4'd3, 4'd1, 1'b0, "rd3");
   endtask

   task automatic test_wrap();
      wq = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_write(4'd14, 4'd3, -1, 0, 1'b0, "wrwrap");
      do_read(4'd14, 4'd3, 1'b0, "rdwrap");
      do_read(4'd0, 4'd1, 1'b0, "rdwrap0");
   endtask

   task automatic test_backpressure();
      do_read(4'd4, 4'd3, 1'b1, "rdstall");
   endtask

   task automatic test_write_gaps();
      wq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
      do_write(4'd8, 4'd5, 2, 2, 1'b1, "wrgap");
      do_read(4'd8, 4'd5, 1'b0, "rdgap");
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] e;
      for (int i = 4; i < 8; i++) sq.push_back(model_mem[i]);
      send_cmd(CMD_READ, 4'd4, 4'd3);
      @(negedge clk);
      cmd_valid = 1'b0;
      rd_ready  = 1'b1;
      e = sq.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         bad++;
         $display("FAIL rstrd_beat1 rd_valid/rd_data got=%b/%h exp=1/%h", rd_valid, rd_data, e);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({rd_valid, cmd_ready, done, wr_ready} !== 4'b0100 || rd_data !== 8'h00 || chk !== 8'h00) begin
         bad++;
         $display("FAIL rstrd_state rd_valid/cmd_ready/done/wr_ready=%b rd_data=%h chk=%h exp=0100/00/00",
                  {rd_valid, cmd_ready, done, wr_ready}, rd_data, chk);
      end
      rst      = 1'b0;
      rd_ready = 1'b0;
      sq.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstrd_nodone done/rd_valid got=%b%b exp=00", done, rd_valid);
         end
      end
      do_read(4'd4, 4'd3, 1'b0, "rstrd_reread");
   endtask

   task automatic test_checksum();
      wq = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
      do_write(4'd9, 4'd3, -1, 0, 1'b0, "wrchk");
      wq = '{8'h3C};
      do_write(4'd13, 4'd0, -1, 0, 1'b0, "wrchk1");
      do_read(4'd9, 4'd4, 1'b1, "rdchk");
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_idle_ignore();
      test_wrap();
      test_backpressure();
      test_write_gaps();
      test_reset_mid_read();
      test_checksum();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
